muldiv_sequencer: RTL and testbench
===================================

// Module: muldiv_sequencer
// PURPOSE
//  Iterative RV32M multiply/divide unit that sits beside ALU_stage in EX.
//  Accepts one M-extension op (opcode 0110011, funct7 0000001) and runs a
//  shift-add multiply or restoring divide, one bit per cycle.
//  Holds the pipeline with stall until the result is ready.
//  Returns the result together with the destination register tag.
// PARAMETERS
//  XLEN  32  operand/result width; iteration count = XLEN; counter width = $clog2(XLEN)+1
// PORTS
//  clk         in   1     single clock, all state on rising edge
//  rst         in   1     asynchronous, active-high reset
//  start       in   1     issue request, sampled on clk; only accepted in IDLE or DONE
//  flush       in   1     synchronous abort of the in-flight op
//  funct3      in   3     0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU
//  regdataA    in   XLEN  rs1 operand
//  regdataB    in   XLEN  rs2 operand
//  regdest     in   5     rd tag
//  busy        out  1     registered; high in CALC and FIX
//  stall       out  1     combinational: (start & accept) | busy; low in DONE
//  done        out  1     registered; one-cycle result-valid pulse
//  result      out  XLEN  registered result; holds until the next done
//  regdestOut  out  5     rd tag of result; updates with result
// BEHAVIOUR
//  Reset (async): state=IDLE; busy=0, done=0, result=0, regdestOut=0, counter=0.
//  FSM: IDLE -start-> CALC -32 iters-> FIX -> DONE -> IDLE (DONE -start-> CALC).
//  Accept edge (k): latch funct3, regdest, |A|, |B|, result-sign, dividend-sign; counter=0.
//  CALC: edges k+1..k+32, one iteration each; 32nd iteration moves to FIX.
//   MUL*: 64-bit product register, add-shift on magnitudes.
//   DIV*/REM*: 33-bit partial remainder, restoring subtract.
//  FIX (edge k+33): two's-complement sign correction, load result/regdestOut, go to DONE.
//  Latency: done is high in the cycle after edge k+33, for exactly one cycle.
//  Result selection:
//   MUL = low 32 bits; MULH/MULHSU/MULHU = high 32 bits with signed/signed,
//   signed/unsigned and unsigned/unsigned operands respectively.
//   DIV/REM: quotient sign = sA^sB; remainder sign = sign of dividend.
//  Boundaries (RISC-V mandated):
//   divide by zero: DIV/DIVU = 0xFFFFFFFF, REM/REMU = dividend.
//   DIV 0x80000000 / 0xFFFFFFFF = 0x80000000; REM of the same = 0.
//  start while busy: ignored; no queueing.
//  start during DONE: accepted, so back-to-back ops are allowed; DONE -> CALC.
//  flush: next edge forces IDLE, clears busy, no done pulse, result unchanged.
//   flush+start in the same cycle: flush wins, start dropped.
//   flush in the DONE cycle: done still seen this cycle, state -> IDLE.
//  rst asserted mid-op: immediate IDLE and reset values, no done.
//  funct3 is not re-sampled after accept; input changes during CALC have no effect.
// CONFIGURATION
//  MULDIV_EARLY_OUT_EN defined:
//   divide-by-zero, DIV overflow, or a MUL* op with either operand 0 skips CALC/FIX.
//   Accept edge loads result directly and enters DONE, so done is high in the
//   cycle after edge k; stall is high only in the start cycle.
//  MULDIV_EARLY_OUT_EN undefined:
//   every op takes the full 33-edge latency; special-case values are still
//   produced, computed in FIX.
// TESTING
//  MUL 7*6, rd=5 -> done 33 edges after accept; result=42; regdestOut=5; stall high 33 cycles.
//  MULH 0xFFFFFFFF*0xFFFFFFFF -> 0; MULHU of same -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF,2 -> 0xFFFFFFFF.
//  DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU -> 2.
//  DIV 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5; DIV 0x80000000/-1 -> 0x80000000 (1-cycle with _EN).
//  Mid-CALC flush then start DIVU 9/3 -> no done for the first op; second op gives 3 at full latency.
//  rst pulse at iteration 10 -> busy=done=result=0 at once; start in DONE cycle -> back-to-back results correct.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide, one bit per cycle.
// Optional MULDIV_EARLY_OUT_EN: zero-operand multiply, divide-by-zero and DIV overflow finish on the accept edge.
module muldiv_sequencer #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] regdataA,
    input  logic [XLEN-1:0] regdataB,
    input  logic [4:0]      regdest,
    output logic            busy,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      regdestOut
);

    localparam int unsigned CW = $clog2(XLEN) + 1;
    localparam int unsigned W2 = 2 * XLEN;
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t          state;
    logic [2:0]      op;
    logic [4:0]      rd;
    logic [XLEN-1:0] mag_a;
    logic [XLEN-1:0] mag_b;
    logic            neg_res;
    logic            neg_rem;
    logic            div_zero;
    logic [W2-1:0]   prod;
    logic [XLEN-1:0] rem;
    logic [CW-1:0]   count;

    // Operand decode at issue: signedness per funct3, magnitudes and sign flags
    logic            accept;
    logic            in_is_div;
    logic            in_a_signed;
    logic            in_b_signed;
    logic            in_sa;
    logic            in_sb;
    logic            in_div_zero;
    logic [XLEN-1:0] in_abs_a;
    logic [XLEN-1:0] in_abs_b;

    always_comb begin
        accept      = (state == S_IDLE || state == S_DONE) && start && !flush;
        in_is_div   = funct3[2];
        in_a_signed = in_is_div ? !funct3[0] : (funct3[1:0] != 2'b11);
        in_b_signed = in_is_div ? !funct3[0] : !funct3[1];
        in_sa       = in_a_signed && regdataA[XLEN-1];
        in_sb       = in_b_signed && regdataB[XLEN-1];
        in_abs_a    = in_sa ? XLEN'(-regdataA) : regdataA;
        in_abs_b    = in_sb ? XLEN'(-regdataB) : regdataB;
        in_div_zero = in_is_div && (regdataB == '0);
    end

    assign stall = accept | busy;

`ifdef MULDIV_EARLY_OUT_EN
    // Special cases whose result is known from the raw operands
    logic            early_hit;
    logic            early_ovf;
    logic [XLEN-1:0] early_val;

    always_comb begin
        early_ovf = in_is_div && !funct3[0] && (regdataA == MIN_NEG) && (regdataB == '1);
        early_hit = in_div_zero || early_ovf ||
                    (!in_is_div && ((regdataA == '0) || (regdataB == '0)));
        early_val = '0;
        if (in_div_zero) begin
            early_val = funct3[1] ? regdataA : '1;
        end else if (early_ovf) begin
            early_val = funct3[1] ? '0 : MIN_NEG;
        end
    end
`endif

    // One iteration: add-shift for multiply, restoring subtract for divide
    logic [XLEN:0]   mul_sum;
    logic [W2-1:0]   mul_next;
    logic [XLEN:0]   rem_sh;
    logic            rem_ge;
    logic [XLEN-1:0] rem_next;
    logic [XLEN-1:0] q_next;

    always_comb begin
        mul_sum  = {1'b0, prod[W2-1:XLEN]} + (prod[0] ? {1'b0, mag_a} : '0);
        mul_next = {mul_sum, prod[XLEN-1:1]};
        rem_sh   = {rem, prod[XLEN-1]};
        rem_ge   = rem_sh >= {1'b0, mag_b};
        rem_next = rem_ge ? XLEN'(rem_sh - {1'b0, mag_b}) : rem_sh[XLEN-1:0];
        q_next   = {prod[XLEN-2:0], rem_ge};
    end

    // Sign correction and result selection
    logic [W2-1:0]   prod_fix;
    logic [XLEN-1:0] quot_fix;
    logic [XLEN-1:0] rem_fix;
    logic [XLEN-1:0] fix_result;

    always_comb begin
        prod_fix = neg_res ? W2'(-prod) : prod;
        quot_fix = neg_res ? XLEN'(-prod[XLEN-1:0]) : prod[XLEN-1:0];
        rem_fix  = neg_rem ? XLEN'(-rem) : rem;
        case (op)
            3'd0:          fix_result = prod_fix[XLEN-1:0];
            3'd1, 3'd2,
            3'd3:          fix_result = prod_fix[W2-1:XLEN];
            3'd4, 3'd5:    fix_result = div_zero ? '1 : quot_fix;
            default:       fix_result = rem_fix;
        endcase
    end

    // Sequencer with registered outputs; flush overrides everything but reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            result     <= '0;
            regdestOut <= '0;
            count      <= '0;
            op         <= '0;
            rd         <= '0;
            mag_a      <= '0;
            mag_b      <= '0;
            neg_res    <= 1'b0;
            neg_rem    <= 1'b0;
            div_zero   <= 1'b0;
            prod       <= '0;
            rem        <= '0;
        end else begin
            done <= 1'b0;
            if (flush) begin
                state <= S_IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    S_IDLE, S_DONE: begin
                        if (start) begin
                            op       <= funct3;
                            rd       <= regdest;
                            mag_a    <= in_abs_a;
                            mag_b    <= in_abs_b;
                            neg_res  <= in_sa ^ in_sb;
                            neg_rem  <= in_sa;
                            div_zero <= in_div_zero;
                            count    <= '0;
                            rem      <= '0;
                            prod     <= in_is_div ? {XLEN'(0), in_abs_a} : {XLEN'(0), in_abs_b};
`ifdef MULDIV_EARLY_OUT_EN
                            if (early_hit) begin
                                result     <= early_val;
                                regdestOut <= regdest;
                                done       <= 1'b1;
                                state      <= S_DONE;
                            end else begin
                                state <= S_CALC;
                                busy  <= 1'b1;
                            end
`else
                            state <= S_CALC;
                            busy  <= 1'b1;
`endif
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                    S_CALC: begin
                        if (op[2]) begin
                            rem  <= rem_next;
                            prod <= {prod[W2-1:XLEN], q_next};
                        end else begin
                            prod <= mul_next;
                        end
                        count <= count + CW'(1);
                        if (count == CW'(XLEN - 1)) begin
                            state <= S_FIX;
                        end
                    end
                    S_FIX: begin
                        result     <= fix_result;
                        regdestOut <= rd;
                        done       <= 1'b1;
                        busy       <= 1'b0;
                        state      <= S_DONE;
                    end
                    default: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: vector table plus flush, reset and back-to-back sequences.
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        flush;
    logic [2:0]  funct3;
    logic [31:0] regdataA;
    logic [31:0] regdataB;
    logic [4:0]  regdest;
    logic        busy;
    logic        stall;
    logic        done;
    logic [31:0] result;
    logic [4:0]  regdestOut;

`ifdef MULDIV_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif
    localparam int FULL_LAT = 33;

    muldiv_sequencer #(.XLEN(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .flush      (flush),
        .funct3     (funct3),
        .regdataA   (regdataA),
        .regdataB   (regdataB),
        .regdest    (regdest),
        .busy       (busy),
        .stall      (stall),
        .done       (done),
        .result     (result),
        .regdestOut (regdestOut)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
        bit          early;
    } vec_t;

    vec_t vecs[20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one request away from the edge, confirm stall, then scramble inputs after accept
    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input string name);
        funct3   = f3;
        regdataA = a;
        regdataB = b;
        regdest  = rd;
        start    = 1'b1;
        #1;
        chk({name, " stall_start"}, 32'(stall), 32'd1);
        @(posedge clk);
        #1;
        start    = 1'b0;
        funct3   = ~f3;
        regdataA = $urandom;
        regdataB = $urandom;
        regdest  = ~rd;
    endtask

    task automatic wait_done(input int exp_lat, input logic [31:0] exp_res,
                             input logic [4:0] exp_rd, input string name);
        int lat = 0;
        int st  = 0;
        while (!done && lat < 100) begin
            if (stall) st++;
            @(posedge clk);
            #1;
            lat++;
        end
        chk({name, " latency"}, 32'(lat), 32'(exp_lat));
        chk({name, " stall_cycles"}, 32'(st), 32'(exp_lat));
        chk({name, " result"}, result, exp_res);
        chk({name, " rd"}, 32'(regdestOut), 32'(exp_rd));
    endtask

    task automatic no_done(input int n, input string name);
        int seen = 0;
        repeat (n) begin
            @(posedge clk);
            #1;
            if (done) seen++;
        end
        chk({name, " no_done"}, 32'(seen), 32'd0);
    endtask

    initial begin
        vecs[0]  = '{3'd0, 32'd7,        32'd6,        5'd5,  32'd42,       1'b0};
        vecs[1]  = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1,  32'h00000000, 1'b0};
        vecs[2]  = '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2,  32'hFFFFFFFE, 1'b0};
        vecs[3]  = '{3'd2, 32'hFFFFFFFF, 32'd2,        5'd3,  32'hFFFFFFFF, 1'b0};
        vecs[4]  = '{3'd4, 32'hFFFFFFF9, 32'd2,        5'd4,  32'hFFFFFFFD, 1'b0};
        vecs[5]  = '{3'd6, 32'hFFFFFFF9, 32'd2,        5'd6,  32'hFFFFFFFF, 1'b0};
        vecs[6]  = '{3'd5, 32'd100,      32'd7,        5'd7,  32'd14,       1'b0};
        vecs[7]  = '{3'd7, 32'd100,      32'd7,        5'd8,  32'd2,        1'b0};
        vecs[8]  = '{3'd4, 32'd5,        32'd0,        5'd9,  32'hFFFFFFFF, 1'b1};
        vecs[9]  = '{3'd6, 32'd5,        32'd0,        5'd10, 32'd5,        1'b1};
        vecs[10] = '{3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd11, 32'h80000000, 1'b1};
        vecs[11] = '{3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd12, 32'h00000000, 1'b1};
        vecs[12] = '{3'd0, 32'h12345678, 32'd0,        5'd13, 32'h00000000, 1'b1};
        vecs[13] = '{3'd1, 32'h80000000, 32'h80000000, 5'd14, 32'h40000000, 1'b0};
        vecs[14] = '{3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd15, 32'h00000001, 1'b0};
        vecs[15] = '{3'd4, 32'd7,        32'hFFFFFFFE, 5'd16, 32'hFFFFFFFD, 1'b0};
        vecs[16] = '{3'd6, 32'd7,        32'hFFFFFFFE, 5'd17, 32'd1,        1'b0};
        vecs[17] = '{3'd7, 32'hFFFFFFF0, 32'd0,        5'd18, 32'hFFFFFFF0, 1'b1};
        vecs[18] = '{3'd4, 32'hFFFFFFFB, 32'd0,        5'd19, 32'hFFFFFFFF, 1'b1};
        vecs[19] = '{3'd3, 32'h80000000, 32'd2,        5'd20, 32'd1,        1'b0};

        rst      = 1'b1;
        start    = 1'b0;
        flush    = 1'b0;
        funct3   = '0;
        regdataA = '0;
        regdataB = '0;
        regdest  = '0;
        #1;
        chk("reset busy",   32'(busy),       32'd0);
        chk("reset done",   32'(done),       32'd0);
        chk("reset stall",  32'(stall),      32'd0);
        chk("reset result", result,          32'd0);
        chk("reset rd",     32'(regdestOut), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 20; i++) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            issue(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].rd, nm);
            wait_done((EARLY && vecs[i].early) ? 0 : FULL_LAT, vecs[i].exp, vecs[i].rd, nm);
            @(posedge clk);
            #1;
            chk({nm, " done_pulse"}, 32'(done), 32'd0);
        end

        // Flush mid-CALC with a competing start, then flush+start while idle
        issue(3'd0, 32'd7, 32'd6, 5'd3, "flush_op");
        repeat (5) @(posedge clk);
        #1;
        flush    = 1'b1;
        start    = 1'b1;
        funct3   = 3'd5;
        regdataA = 32'd9;
        regdataB = 32'd3;
        @(posedge clk);
        #1;
        chk("flush busy",   32'(busy),       32'd0);
        chk("flush done",   32'(done),       32'd0);
        chk("flush result", result,          32'd1);
        chk("flush rd",     32'(regdestOut), 32'd20);
        @(posedge clk);
        #1;
        flush = 1'b0;
        start = 1'b0;
        chk("flush_start busy", 32'(busy), 32'd0);
        no_done(40, "flush");
        issue(3'd5, 32'd9, 32'd3, 5'd21, "after_flush");
        wait_done(FULL_LAT, 32'd3, 5'd21, "after_flush");

        // Back-to-back: new start in the DONE cycle
        @(posedge clk);
        #1;
        issue(3'd4, 32'hFFFFFFF9, 32'd2, 5'd22, "b2b_first");
        wait_done(FULL_LAT, 32'hFFFFFFFD, 5'd22, "b2b_first");
        issue(3'd7, 32'd100, 32'd7, 5'd23, "b2b_second");
        wait_done(FULL_LAT, 32'd2, 5'd23, "b2b_second");

        // Flush during the DONE cycle
        issue(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd25, "done_flush");
        wait_done(FULL_LAT, 32'hFFFFFFFE, 5'd25, "done_flush");
        flush = 1'b1;
        start = 1'b1;
        chk("done_flush done_seen", 32'(done), 32'd1);
        @(posedge clk);
        #1;
        flush = 1'b0;
        start = 1'b0;
        chk("done_flush busy", 32'(busy), 32'd0);
        chk("done_flush done", 32'(done), 32'd0);
        no_done(40, "done_flush");

        // Asynchronous reset mid-CALC
        issue(3'd0, 32'd7, 32'd6, 5'd24, "rst_op");
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst busy",   32'(busy),       32'd0);
        chk("midrst done",   32'(done),       32'd0);
        chk("midrst stall",  32'(stall),      32'd0);
        chk("midrst result", result,          32'd0);
        chk("midrst rd",     32'(regdestOut), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        no_done(40, "midrst");
        @(negedge clk);
        issue(3'd0, 32'd7, 32'd6, 5'd5, "after_rst");
        wait_done(FULL_LAT, 32'd42, 5'd5, "after_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
